// File: rtl/uart_frame_ctrl.sv
// Frame decoder for 4-byte UART register-write frames: HDR, ADDR, DATA, CHK.
// Checksum is (ADDR + DATA) mod 256; an inter-byte timeout aborts partial frames.
module uart_frame_ctrl #(
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_ADDR = 2'd1;
  localparam logic [1:0] ST_GET_DATA = 2'd2;
  localparam logic [1:0] ST_GET_CHK  = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]  r_state;
  logic [15:0] r_tmo_cnt;
  logic [7:0]  r_addr_lat;
  logic [7:0]  r_data_lat;
  logic        r_wr_en;
  logic        r_frame_err;
  logic [7:0]  r_reg_addr;
  logic [7:0]  r_reg_wdata;
  logic [7:0]  r_err_cnt;

  logic [7:0]  w_sum;
  logic        w_chk_ok;
  logic        w_timeout;
  logic        w_chk_byte;
  logic        w_err_next;

  assign w_sum      = r_addr_lat + r_data_lat;
  assign w_chk_ok   = (w_sum == rx_data);
  // A byte arriving in the timeout cycle wins over the timeout.
  assign w_timeout  = (r_state != ST_IDLE) && (r_tmo_cnt == TO_LAST) && !rx_done;
  assign w_chk_byte = rx_done && (r_state == ST_GET_CHK);
  assign w_err_next = w_timeout || (w_chk_byte && !w_chk_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_addr_lat  <= '0;
      r_data_lat  <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_frame_err <= w_err_next;
      if (w_err_next && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      if (w_timeout) begin
        r_state   <= ST_IDLE;
        r_tmo_cnt <= '0;
      end else if (rx_done) begin
        r_tmo_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (rx_data == HDR_BYTE) begin
              r_state <= ST_GET_ADDR;
            end
          end
          ST_GET_ADDR: begin
            r_addr_lat <= rx_data;
            r_state    <= ST_GET_DATA;
          end
          ST_GET_DATA: begin
            r_data_lat <= rx_data;
            r_state    <= ST_GET_CHK;
          end
          default: begin
            r_state <= ST_IDLE;
            if (w_chk_ok) begin
              r_wr_en     <= 1'b1;
              r_reg_addr  <= r_addr_lat;
              r_reg_wdata <= r_data_lat;
            end
          end
        endcase
      end else if (r_state != ST_IDLE) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end

  assign reg_wr_en = r_wr_en;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: fixed vector table, directed corner sequences,
// and random traffic checked against a byte-queue model of the frame rules.
module tb_uart_frame_ctrl;

  localparam logic [7:0]  HDR = 8'hA5;
  localparam int unsigned TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       frame_err;
  logic       busy;
  logic [7:0] err_cnt;

  uart_frame_ctrl #(.HDR_BYTE(HDR), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .frame_err(frame_err), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: bytes of the frame collected so far, idle edges since last byte.
  logic [7:0] m_q[$];
  int         m_idle;
  logic       m_wr, m_err;
  logic [7:0] m_addr, m_wd;
  int         m_ec;

  typedef struct {
    logic       rd;
    logic [7:0] d;
    logic       wr;
    logic       er;
    logic [7:0] a;
    logic [7:0] w;
    logic       b;
    logic [7:0] ec;
  } vec_t;
  vec_t tbl[20];

  task automatic model_clear();
    m_q.delete();
    m_idle = 0; m_wr = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wd = '0; m_ec = 0;
  endtask

  task automatic model_edge(input logic rd, input logic [7:0] d);
    m_wr = 1'b0; m_err = 1'b0;
    if (rd) begin
      m_idle = 0;
      if (m_q.size() == 0) begin
        if (d == HDR) m_q.push_back(d);
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          if (8'(m_q[1] + m_q[2]) == m_q[3]) begin
            m_wr = 1'b1; m_addr = m_q[1]; m_wd = m_q[2];
          end else begin
            m_err = 1'b1;
          end
          m_q.delete();
        end
      end
    end else if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == int'(TMO)) begin
        m_err = 1'b1;
        m_q.delete();
        m_idle = 0;
      end
    end
    if (m_err && m_ec < 255) m_ec++;
  endtask

  task automatic check(input string name, input logic ew, input logic ee,
                       input logic [7:0] ea, input logic [7:0] ewd,
                       input logic eb, input logic [7:0] ec);
    n_cmp++;
    if ({reg_wr_en, frame_err, reg_addr, reg_wdata, busy, err_cnt} !==
        {ew, ee, ea, ewd, eb, ec}) begin
      n_bad++;
      $display("FAIL %s: got wr=%0b err=%0b addr=%h wd=%h busy=%0b ec=%0d ; want wr=%0b err=%0b addr=%h wd=%h busy=%0b ec=%0d",
               name, reg_wr_en, frame_err, reg_addr, reg_wdata, busy, err_cnt,
               ew, ee, ea, ewd, eb, ec);
    end
  endtask

  task automatic step(input logic rd, input logic [7:0] d);
    rx_done = rd; rx_data = d;
    @(posedge clk);
    model_edge(rd, d);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic step_m(input string name, input logic rd, input logic [7:0] d);
    step(rd, d);
    check(name, m_wr, m_err, m_addr, m_wd, (m_q.size() != 0), 8'(m_ec));
  endtask

  task automatic do_reset();
    rx_done = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_async", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    check("reset_hold", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int k;
    int hit;
    int r;
    logic [7:0] b;

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0};
    tbl[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0};
    tbl[3]  = '{1'b1, 8'h46, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 8'd0};
    tbl[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 8'd0};
    tbl[7]  = '{1'b1, 8'h34, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 8'd0};
    tbl[8]  = '{1'b1, 8'h47, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 8'd1};
    tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 8'd1};
    tbl[14] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 8'd1};
    tbl[15] = '{1'b1, 8'h03, 1'b1, 1'b0, 8'h01, 8'h02, 1'b0, 8'd1};
    tbl[16] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h01, 8'h02, 1'b1, 8'd1};
    tbl[17] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h01, 8'h02, 1'b1, 8'd1};
    tbl[18] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 8'h02, 1'b1, 8'd1};
    tbl[19] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'd1};

    model_clear();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rd, tbl[i].d);
      check($sformatf("table[%0d]", i), tbl[i].wr, tbl[i].er, tbl[i].a,
            tbl[i].w, tbl[i].b, tbl[i].ec);
    end

    // Timeout: error exactly TMO edges after the last byte.
    do_reset();
    step_m("to_hdr", 1'b1, HDR);
    step_m("to_addr", 1'b1, 8'h10);
    hit = -1;
    for (k = 1; k <= 200; k++) begin
      step_m("to_wait", 1'b0, 8'h00);
      if (frame_err) begin hit = k; break; end
    end
    n_cmp++;
    if (hit != int'(TMO)) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles, want %0d", hit, TMO);
    end
    check("to_after", 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'd1);
    step_m("to_f1", 1'b1, HDR);
    step_m("to_f2", 1'b1, 8'h20);
    step_m("to_f3", 1'b1, 8'h30);
    step_m("to_f4", 1'b1, 8'h50);
    check("to_write", 1'b1, 1'b0, 8'h20, 8'h30, 1'b0, 8'd1);

    // Byte landing in the timeout cycle is taken, no error.
    do_reset();
    step_m("co_hdr", 1'b1, HDR);
    for (int i = 1; i < int'(TMO); i++) step_m("co_wait", 1'b0, 8'h00);
    step_m("co_byte", 1'b1, 8'h07);
    check("co_no_err", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0);
    step_m("co_d", 1'b1, 8'h01);
    step_m("co_c", 1'b1, 8'h08);
    check("co_write", 1'b1, 1'b0, 8'h07, 8'h01, 1'b0, 8'd0);

    // Error counter saturation.
    do_reset();
    for (int f = 0; f < 300; f++) begin
      step_m("sat_h", 1'b1, HDR);
      step_m("sat_a", 1'b1, 8'h01);
      step_m("sat_d", 1'b1, 8'h02);
      step_m("sat_c", 1'b1, 8'h04);
    end
    check("sat_255", 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'd255);
    step_m("sat_g1", 1'b1, HDR);
    step_m("sat_g2", 1'b1, 8'h33);
    step_m("sat_g3", 1'b1, 8'h44);
    step_m("sat_g4", 1'b1, 8'h77);
    check("sat_write", 1'b1, 1'b0, 8'h33, 8'h44, 1'b0, 8'd255);

    // Reset mid-frame drops the partial frame.
    do_reset();
    step_m("mr_h", 1'b1, HDR);
    step_m("mr_a", 1'b1, 8'h12);
    do_reset();
    step_m("mr_x", 1'b1, 8'h34);
    check("mr_idle", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
    step_m("mr_f1", 1'b1, HDR);
    step_m("mr_f2", 1'b1, 8'h01);
    step_m("mr_f3", 1'b1, 8'h01);
    step_m("mr_f4", 1'b1, 8'h02);
    check("mr_write", 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 8'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        k = int'($urandom_range(95, 110));
        for (int j = 0; j < k; j++) step_m("rnd_gap", 1'b0, 8'h00);
      end else if (r < 35) begin
        step_m("rnd_idle", 1'b0, 8'(($urandom)));
      end else begin
        b = 8'($urandom);
        if (m_q.size() == 0 && $urandom_range(0, 9) < 7) b = HDR;
        if (m_q.size() == 3 && $urandom_range(0, 9) < 7) b = 8'(m_q[1] + m_q[2]);
        step_m("rnd_byte", 1'b1, b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter HDR_BYTE, default 8'hA5, frame header value.
REQ-002 Parameter TIMEOUT_CYC, default 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz); legal range 2..65535.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_done  input  1  one-cycle strobe from UART receiver: rx_data valid this cycle.
REQ-006 rx_data  input  8  received byte, sampled only when rx_done=1.
REQ-007 reg_wr_en  output  1  one-cycle register write strobe.
REQ-008 reg_addr  output  8  write address, valid with reg_wr_en and held until the next write.
REQ-009 reg_wdata  output  8  write data, valid with reg_wr_en and held until the next write.
REQ-010 frame_err  output  1  one-cycle pulse on checksum mismatch or timeout.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-013 Frame format SHALL be 4 bytes in order: HDR_BYTE, ADDR, DATA, CHK, where CHK = (ADDR + DATA) mod 256.
REQ-014 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, GET_CHK, and all transitions SHALL occur only on rx_done or timeout.
REQ-015 IDLE: rx_done with rx_data==HDR_BYTE -> GET_ADDR; any other byte is ignored with no error and no state change.
REQ-016 GET_ADDR: rx_done -> latch ADDR, go to GET_DATA; GET_DATA: rx_done -> latch DATA, go to GET_CHK.
REQ-017 GET_CHK: rx_done -> go to IDLE; on checksum match, reg_wr_en=1 for exactly one cycle, the cycle after that rx_done, with reg_addr/reg_wdata updated in the same cycle.
REQ-018 GET_CHK checksum mismatch: frame_err=1 for one cycle, the cycle after rx_done; no write; reg_addr/reg_wdata unchanged.
REQ-019 A byte equal to HDR_BYTE arriving in GET_ADDR/GET_DATA/GET_CHK SHALL be treated as ordinary frame content (no resynchronisation).
REQ-020 A 16-bit timeout counter SHALL clear on every rx_done and on entry to IDLE, and count up each cycle while not IDLE.
REQ-021 When the counter reaches TIMEOUT_CYC-1 with no rx_done in that cycle, the FSM SHALL return to IDLE with a one-cycle frame_err pulse on the following cycle.
REQ-022 rx_done coincident with the timeout cycle: the byte SHALL be processed normally and no timeout is raised.
REQ-023 err_cnt SHALL increment by 1 on each frame_err pulse and hold at 255 (no wrap).
REQ-024 reg_wr_en and frame_err SHALL never be asserted in the same cycle.
REQ-025 busy SHALL be combinational from state: 1 in GET_ADDR, GET_DATA and GET_CHK; 0 in IDLE.
REQ-026 Back-to-back frames with rx_done on consecutive cycles SHALL be accepted with no dead cycle between frames.

Reset
REQ-027 While rst=1: state=IDLE; timeout counter=0; reg_wr_en=0; reg_addr=0; reg_wdata=0; frame_err=0; err_cnt=0; busy=0.
REQ-028 rst asserted mid-frame SHALL discard the partial frame with no write and no frame_err; after release, a fresh header is required.

Verification
REQ-029 Good frame A5,12,34,46 -> single reg_wr_en pulse with reg_addr=8'h12 and reg_wdata=8'h34, one cycle after the 4th rx_done; frame_err stays 0.
REQ-030 Bad checksum A5,12,34,47 -> frame_err pulse, err_cnt 0->1, no reg_wr_en, reg_addr/reg_wdata keep their previous values.
REQ-031 Noise 00,FF,A5,01,02,03 -> one write addr=01, data=02; leading bytes ignored; err_cnt unchanged.
REQ-032 TIMEOUT_CYC=100: A5,10 then idle -> frame_err 100 cycles after the last rx_done, busy drops; a following A5,20,30,50 writes addr=20, data=30.
REQ-033 300 consecutive bad frames -> err_cnt saturates at 255; one good frame still produces a write.
REQ-034 rst pulse after A5,12 then frame A5,01,01,02 -> no write for the aborted frame, err_cnt=0, one write addr=01, data=01.
